// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller
//   Sequences the signed duty command for one motor PWM channel. Targets come
//   in over a valid/ready handshake. They are clamped to +/-PERIOD. The applied
//   duty then slews toward the target by 'step' once per PWM period. Every
//   direction reversal gets a zero-duty dead period. A command watchdog forces
//   a ramp to zero if no target arrives in time.
//
// Ports
//   clk           system clock
//   reset         asynchronous, active-low reset
//   enable        channel enable; low forces duty to zero and returns to IDLE
//   target_duty   signed target duty in clock counts (24 bit)
//   target_valid  target_duty is valid
//   target_ready  always 1; a target is accepted whenever target_valid is 1
//   step          unsigned slew per period; 0 jumps straight to the target
//   duty          |applied| to the pwm generator (registered)
//   dir           1 when applied duty is negative (registered)
//   period_tick   one-cycle pulse at the end of each PWM period
//   wdt_expired   sticky watchdog flag, cleared by an accepted target or enable=0
//   state         current FSM state, for debug
module pwm_ramp_controller #(
   parameter int CLK_FREQ    = 32_000_000,
   parameter int PWM_FREQ    = 20_000,
   parameter int WDT_PERIODS = 2000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [23:0] target_duty,
   input  logic        target_valid,
   output logic        target_ready,
   input  logic [15:0] step,
   output logic [23:0] duty,
   output logic        dir,
   output logic        period_tick,
   output logic        wdt_expired,
   output logic [2:0]  state
);

   localparam int PERIOD = CLK_FREQ / PWM_FREQ;
   localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam int WW     = $clog2(WDT_PERIODS + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RAMP    = 3'd1;
   localparam logic [2:0] S_HOLD    = 3'd2;
   localparam logic [2:0] S_REVERSE = 3'd3;
   localparam logic [2:0] S_TIMEOUT = 3'd4;

   localparam logic signed [24:0] PER_POS = 25'(PERIOD);
   localparam logic signed [24:0] PER_NEG = -PER_POS;

   logic [CW-1:0]      cnt;
   logic [WW-1:0]      wdt_cnt;
   logic signed [24:0] applied, target;
   logic signed [24:0] tgt_in, tgt_sat, diff, mag, step_s, cand_raw, cand, abs_app;
   logic               last_neg;   // sign of the last nonzero applied value
   logic               accept, crosses, wdt_trip, need_rev;

   assign target_ready = 1'b1;
   assign accept       = target_valid && target_ready;
   // A target accepted in the same cycle as the trip takes priority.
   assign wdt_trip     = (wdt_cnt == WW'(WDT_PERIODS)) && !accept;

   always_comb begin
      tgt_in  = {target_duty[23], target_duty};
      tgt_sat = tgt_in;
      if (tgt_in > PER_POS)      tgt_sat = PER_POS;
      else if (tgt_in < PER_NEG) tgt_sat = PER_NEG;

      diff   = target - applied;
      mag    = diff[24] ? -diff : diff;
      step_s = {9'd0, step};

      if (step == '0 || mag <= step_s) cand_raw = target;
      else if (diff[24])               cand_raw = applied - step_s;
      else                             cand_raw = applied + step_s;

      // Never pass straight through zero: stop at 0 so a dead period can follow.
      crosses = (applied != '0) && (cand_raw != '0) && (cand_raw[24] != applied[24]);
      cand    = crosses ? '0 : cand_raw;

      // At zero with a target pointing the other way: a reversal is due.
      need_rev = (target != '0) && (target[24] != last_neg);

      abs_app = applied[24] ? -applied : applied;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt         <= '0;
         period_tick <= 1'b0;
         applied     <= '0;
         target      <= '0;
         wdt_cnt     <= '0;
         wdt_expired <= 1'b0;
         last_neg    <= 1'b0;
         duty        <= '0;
         dir         <= 1'b0;
         state       <= S_IDLE;
      end else begin
         cnt         <= (cnt == CW'(PERIOD - 1)) ? '0 : cnt + CW'(1);
         period_tick <= (cnt == CW'(PERIOD - 1));

         // Gating with enable here gives duty=0 on the cycle right after enable falls.
         duty <= enable ? abs_app[23:0] : '0;
         dir  <= enable & last_neg;

         if (accept) target <= tgt_sat;

         if (!enable || accept)
            wdt_cnt <= '0;
         else if (period_tick && state != S_TIMEOUT && wdt_cnt != WW'(WDT_PERIODS))
            wdt_cnt <= wdt_cnt + WW'(1);

         if (!enable) begin
            state       <= S_IDLE;
            applied     <= '0;
            last_neg    <= 1'b0;
            wdt_expired <= 1'b0;
         end else begin
            if (accept) wdt_expired <= 1'b0;
            case (state)
               S_IDLE: state <= S_RAMP;

               S_RAMP: begin
                  if (wdt_trip) begin
                     state       <= S_TIMEOUT;
                     target      <= '0;
                     wdt_expired <= 1'b1;
                  end else if (period_tick) begin
                     if (applied == '0 && need_rev) begin
                        state <= S_REVERSE;
                     end else begin
                        applied <= cand;
                        if (cand != '0) last_neg <= cand[24];
                        if (cand == '0 && need_rev)
                           state <= S_REVERSE;
                        else if (cand == target && !(accept && tgt_sat != cand))
                           state <= S_HOLD;
                     end
                  end
               end

               S_HOLD: begin
                  if (wdt_trip) begin
                     state       <= S_TIMEOUT;
                     target      <= '0;
                     wdt_expired <= 1'b1;
                  end else if (accept && tgt_sat != applied) begin
                     state <= S_RAMP;
                  end
               end

               S_REVERSE: begin
                  if (wdt_trip) begin
                     state       <= S_TIMEOUT;
                     target      <= '0;
                     wdt_expired <= 1'b1;
                  end else if (period_tick) begin
                     // Dead period done: flip direction, no duty step this tick.
                     last_neg <= target[24];
                     state    <= S_RAMP;
                  end
               end

               S_TIMEOUT: begin
                  if (period_tick) begin
                     applied <= cand;
                     if (cand != '0) last_neg <= cand[24];
                  end
                  if (accept) state <= S_RAMP;
               end

               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
